lut_coeff_loader: RTL and testbench

- Runtime writer for the interpolation coefficient LUTs (c0/c1 style tables: 256 bins x 14 segments per table).
- Streams NUM_TABLES x DEPTH words from a host/DMA valid/ready stream into the single-port LUT RAMs through their address/data/wren ports.
- After loading, reads every location back through rden/q and checks a wrap-around sum, so a corrupted table is flagged before force evaluation starts.

---
 rtl/lut_coeff_loader.sv | 191 +++++++++++++++++++
 tb/tb_lut_coeff_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_coeff_loader.sv
// rtl/lut_coeff_loader.sv - streams coefficient words into the LUT RAMs, then reads them back and checks the sum
module lut_coeff_loader #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 3584,
    parameter int ADDR_WIDTH   = 12,
    parameter int NUM_TABLES   = 4,
    parameter int TSEL_WIDTH   = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [ADDR_WIDTH-1:0]            lut_address,
    output logic [DATA_WIDTH-1:0]            lut_data,
    output logic [NUM_TABLES-1:0]            lut_wren,
    output logic                             lut_rden,
    input  logic [NUM_TABLES*DATA_WIDTH-1:0] lut_q,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [DATA_WIDTH-1:0]            checksum
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [TSEL_WIDTH-1:0] LAST_TSEL = TSEL_WIDTH'(NUM_TABLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_VERIFY,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;

    logic [ADDR_WIDTH-1:0] addr;
    logic [TSEL_WIDTH-1:0] tsel;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [TSEL_WIDTH-1:0] tsel_next;
    logic                  at_end;

    // table of the read currently on the bus, and whether it is the final one
    logic [TSEL_WIDTH-1:0] iss_tsel;
    logic                  rd_last;

    logic                  ret_valid [READ_LATENCY];
    logic                  ret_last  [READ_LATENCY];
    logic [TSEL_WIDTH-1:0] ret_tsel  [READ_LATENCY];

    logic [DATA_WIDTH-1:0] rb_sum;
    logic [DATA_WIDTH-1:0] rb_next;
    logic [DATA_WIDTH-1:0] q_sel;
    logic                  ret_hit;

    assign in_ready = (state == S_LOAD);
    assign busy     = (state == S_LOAD) || (state == S_FLUSH) ||
                      (state == S_VERIFY) || (state == S_WAIT);
    assign at_end   = (addr == LAST_ADDR) && (tsel == LAST_TSEL);

    always_comb begin
        addr_next = addr + ADDR_WIDTH'(1);
        tsel_next = tsel;
        if (addr == LAST_ADDR) begin
            addr_next = '0;
            tsel_next = (tsel == LAST_TSEL) ? '0 : tsel + TSEL_WIDTH'(1);
        end
    end

    always_comb begin
        q_sel = '0;
        for (int t = 0; t < NUM_TABLES; t++) begin
            if (ret_tsel[READ_LATENCY-1] == TSEL_WIDTH'(t)) begin
                q_sel = lut_q[t*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // returns only count while a verify pass is live; stale returns after abort are dropped
    assign ret_hit = ret_valid[READ_LATENCY-1] && ((state == S_VERIFY) || (state == S_WAIT));
    assign rb_next = rb_sum + q_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            addr        <= '0;
            tsel        <= '0;
            iss_tsel    <= '0;
            rd_last     <= 1'b0;
            rb_sum      <= '0;
            checksum    <= '0;
            lut_address <= '0;
            lut_data    <= '0;
            lut_wren    <= '0;
            lut_rden    <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                ret_valid[i] <= 1'b0;
                ret_last[i]  <= 1'b0;
                ret_tsel[i]  <= '0;
            end
        end else begin
            lut_wren <= '0;

            ret_valid[0] <= lut_rden;
            ret_last[0]  <= lut_rden && rd_last;
            ret_tsel[0]  <= iss_tsel;
            for (int i = 1; i < READ_LATENCY; i++) begin
                ret_valid[i] <= ret_valid[i-1];
                ret_last[i]  <= ret_last[i-1];
                ret_tsel[i]  <= ret_tsel[i-1];
            end

            if (ret_hit) begin
                rb_sum <= rb_next;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start && !abort) begin
                        state    <= S_LOAD;
                        addr     <= '0;
                        tsel     <= '0;
                        rd_last  <= 1'b0;
                        checksum <= '0;
                        rb_sum   <= '0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        for (int i = 0; i < READ_LATENCY; i++) begin
                            ret_valid[i] <= 1'b0;
                        end
                    end
                end

                S_LOAD: begin
                    // a word accepted alongside abort is still committed to the RAM
                    if (in_valid) begin
                        lut_address <= addr;
                        lut_data    <= in_data;
                        lut_wren    <= NUM_TABLES'(1) << tsel;
                        checksum    <= checksum + in_data;
                        addr        <= addr_next;
                        tsel        <= tsel_next;
                    end
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (in_valid && at_end) begin
                        state <= S_FLUSH;
                    end
                end

                S_FLUSH, S_VERIFY: begin
                    if (abort) begin
                        state    <= S_IDLE;
                        lut_rden <= 1'b0;
                    end else if ((state == S_VERIFY) && rd_last) begin
                        state    <= S_WAIT;
                        lut_rden <= 1'b0;
                    end else begin
                        state       <= S_VERIFY;
                        lut_rden    <= 1'b1;
                        lut_address <= addr;
                        iss_tsel    <= tsel;
                        rd_last     <= at_end;
                        addr        <= addr_next;
                        tsel        <= tsel_next;
                    end
                end

                S_WAIT: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (ret_valid[READ_LATENCY-1] && ret_last[READ_LATENCY-1]) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        error <= (rb_next != checksum);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_coeff_loader.sv
// tb/tb_lut_coeff_loader.sv - directed bench with a timeline model of the load/verify sequence
module tb_lut_coeff_loader;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int NT    = 2;
    localparam int TW    = 1;
    localparam int RL    = 1;
    localparam int N     = NT * DEPTH;
    localparam int MAXC  = 64;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [DW-1:0]    in_data;
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    lut_address;
    logic [DW-1:0]    lut_data;
    logic [NT-1:0]    lut_wren;
    logic             lut_rden;
    logic [NT*DW-1:0] lut_q;
    logic             busy;
    logic             done;
    logic             error;
    logic [DW-1:0]    checksum;

    lut_coeff_loader #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .NUM_TABLES(NT), .TSEL_WIDTH(TW), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .lut_address(lut_address), .lut_data(lut_data), .lut_wren(lut_wren),
        .lut_rden(lut_rden), .lut_q(lut_q), .busy(busy), .done(done),
        .error(error), .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LUT RAM model; corrupt adds +1 to table 1 addr 2 on readback
    logic [DW-1:0] mem  [NT][DEPTH];
    logic [DW-1:0] qreg [NT];
    logic          corrupt;

    always @(posedge clk) begin
        for (int t = 0; t < NT; t++) begin
            if (lut_wren[t]) mem[t][lut_address] <= lut_data;
            if (lut_rden)
                qreg[t] <= mem[t][lut_address] +
                           ((corrupt && t == 1 && lut_address == AW'(2)) ? 32'd1 : 32'd0);
        end
    end

    always_comb begin
        lut_q = '0;
        for (int t = 0; t < NT; t++) lut_q[t*DW +: DW] = qreg[t];
    end

    int checks;
    int errors;

    logic [DW-1:0] words [N];

    // expected timeline, indexed by cycle after the start edge
    logic [NT-1:0] e_wren [MAXC];
    logic [AW-1:0] e_addr [MAXC];
    logic [DW-1:0] e_data [MAXC];
    logic [DW-1:0] e_cks  [MAXC];
    logic          e_rden [MAXC];
    logic          e_rdy  [MAXC];
    logic          e_busy [MAXC];
    logic          e_done [MAXC];
    logic          e_err  [MAXC];
    int            kat    [MAXC];
    int            acc    [N];
    int            nacc;
    int            first_done;
    int            first_wren;
    int            first_rden;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit vld(input int c, input bit gap);
        return (c >= 1) && (!gap || (c % 2 == 1));
    endfunction

    task automatic build(input bit gap, input int ab, input bit bad);
        int k, f, done_at, last_busy;
        logic [DW-1:0] s;
        k = 0;
        for (int c = 0; c < MAXC; c++) begin
            e_wren[c] = '0; e_addr[c] = '0; e_data[c] = '0; e_rden[c] = 1'b0;
            e_rdy[c] = 1'b0;
            kat[c] = k;
            if (c >= 1 && k < N && (ab < 0 || c <= ab)) begin
                e_rdy[c] = 1'b1;
                if (vld(c, gap)) begin
                    acc[k] = c;
                    k++;
                end
            end
        end
        nacc      = k;
        f         = (k == N) ? acc[N-1] + 1 : 1000;
        done_at   = (ab < 0 && k == N) ? f + N + RL + 1 : 1000;
        last_busy = (k == N) ? f + N + RL : MAXC;
        if (ab >= 0 && ab < last_busy) last_busy = ab;
        for (int c = 0; c < MAXC; c++) begin
            e_busy[c] = (c >= 1 && c <= last_busy);
            e_done[c] = (c >= done_at);
            e_err[c]  = e_done[c] && bad;
            if (c >= f + 1 && c <= f + N && (ab < 0 || c <= ab)) begin
                e_rden[c] = 1'b1;
                e_addr[c] = AW'((c - f - 1) % DEPTH);
            end
            s = '0;
            for (int j = 0; j < nacc; j++) if (acc[j] < c) s = s + words[j];
            e_cks[c] = s;
        end
        for (int j = 0; j < nacc; j++) begin
            e_wren[acc[j]+1] = NT'(1) << (j / DEPTH);
            e_addr[acc[j]+1] = AW'(j % DEPTH);
            e_data[acc[j]+1] = words[j];
        end
    endtask

    task automatic compare(input int c);
        bit bad;
        bad = (lut_wren !== e_wren[c]) || (lut_rden !== e_rden[c]) ||
              (in_ready !== e_rdy[c]) || (busy !== e_busy[c]) ||
              (done !== e_done[c]) || (error !== e_err[c]) ||
              (checksum !== e_cks[c]) ||
              (((e_wren[c] != '0) || e_rden[c]) && (lut_address !== e_addr[c])) ||
              ((e_wren[c] != '0) && (lut_data !== e_data[c]));
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL cycle %0d: got wren=%b rden=%b rdy=%b busy=%b done=%b err=%b addr=%0d data=%0h cks=%0h expected wren=%b rden=%b rdy=%b busy=%b done=%b err=%b addr=%0d data=%0h cks=%0h",
                     c, lut_wren, lut_rden, in_ready, busy, done, error, lut_address, lut_data, checksum,
                     e_wren[c], e_rden[c], e_rdy[c], e_busy[c], e_done[c], e_err[c], e_addr[c], e_data[c], e_cks[c]);
        end
        if (done && first_done < 0) first_done = c;
        if (lut_wren != '0 && first_wren < 0) first_wren = c;
        if (lut_rden && first_rden < 0) first_rden = c;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_wren"}, 32'(lut_wren), 0);
        chk({tag, "_rden"}, 32'(lut_rden), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_checksum"}, checksum, 0);
        chk({tag, "_address"}, 32'(lut_address), 0);
        chk({tag, "_data"}, lut_data, 0);
    endtask

    task automatic run(input bit gap, input int ab, input bit bad, input int xstart,
                       input int rst_at, input int last_c);
        build(gap, ab, bad);
        corrupt    = bad;
        first_done = -1;
        first_wren = -1;
        first_rden = -1;
        @(posedge clk); #1;
        for (int c = 0; c <= last_c; c++) begin
            start    = (c == 0) || (c == xstart);
            abort    = (c == ab);
            in_valid = vld(c, gap);
            in_data  = words[(kat[c] < N) ? kat[c] : N - 1];
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                check_zero("mid_reset");
                break;
            end
            @(negedge clk);
            if (c >= 1) compare(c);
            @(posedge clk); #1;
        end
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic set_words_seq();
        for (int i = 0; i < N; i++) words[i] = DW'(i + 1);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_mem_t%0d_a%0d", tag, i / DEPTH, i % DEPTH),
                mem[i / DEPTH][i % DEPTH], words[i]);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        corrupt  = 1'b0;
        set_words_seq();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: continuous load of 1..8
        run(1'b0, -1, 1'b0, -1, -1, 21);
        chk("t1_first_done", 32'(first_done), 19);
        chk("t1_first_wren", 32'(first_wren), 2);
        chk("t1_first_rden", 32'(first_rden), 10);
        chk("t1_checksum", checksum, 36);
        chk("t1_error", 32'(error), 0);
        check_mem("t1");

        // 4: wrap-around checksum
        words[0] = 32'hFFFF_FFFF;
        words[1] = 32'd2;
        for (int i = 2; i < N; i++) words[i] = '0;
        run(1'b0, -1, 1'b0, -1, -1, 21);
        chk("t4_checksum", checksum, 32'h0000_0001);
        chk("t4_error", 32'(error), 0);
        chk("t4_done", 32'(done), 1);

        // 2: every other cycle invalid
        set_words_seq();
        run(1'b1, -1, 1'b0, -1, -1, 28);
        chk("t2_first_done", 32'(first_done), 26);
        chk("t2_checksum", checksum, 36);
        chk("t2_error", 32'(error), 0);
        check_mem("t2");

        // 3: readback corruption on table 1 addr 2
        run(1'b0, -1, 1'b1, -1, -1, 21);
        chk("t3_done", 32'(done), 1);
        chk("t3_error", 32'(error), 1);
        chk("t3_checksum", checksum, 36);
        corrupt = 1'b0;

        // 5: reset in cycle 5 of the load, then a fresh load
        run(1'b0, -1, 1'b0, -1, 5, 5);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run(1'b0, -1, 1'b0, -1, -1, 21);
        chk("t5_done", 32'(done), 1);
        chk("t5_error", 32'(error), 0);
        chk("t5_checksum", checksum, 36);

        // 6: ignored start in cycle 3, abort in cycle 6, then restart
        run(1'b0, 6, 1'b0, 3, -1, 12);
        chk("t6_checksum", checksum, 21);
        chk("t6_done", 32'(done), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_in_ready", 32'(in_ready), 0);
        run(1'b0, -1, 1'b0, -1, -1, 21);
        chk("t6_restart_first_wren", 32'(first_wren), 2);
        chk("t6_restart_done", 32'(first_done), 19);
        chk("t6_restart_error", 32'(error), 0);
        check_mem("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
